// File: rtl/adc_block_buffer.sv
// 512-word circular sample buffer that advertises whole blocks and serves read bursts.
// Optional build macro ADC_BUF_TEST_PATTERN_EN replaces sample_in with an internal counter.
`timescale 1ns/1ps
module adc_block_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int BLOCK_LEN = 256
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              rdreq,
  output logic [DATA_W-1:0] data_out,
  output logic              is_there_256,
  output logic [ADDR_W:0]   level,
  output logic [15:0]       drop_count,
  output logic              rd_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [ADDR_W:0] BLK_LVL  = (ADDR_W + 1)'(BLOCK_LEN);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_wp;
  logic [ADDR_W-1:0] r_rp;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [0:0]        r_state;

  logic              w_block_rdy;
  logic              w_rd;
  logic              w_full;
  logic              w_wr_acc;
  logic              w_drop;
  logic              w_last;
  logic [DATA_W-1:0] w_wdata;

  assign w_block_rdy  = (level >= BLK_LVL);
  assign w_rd         = rdreq & ((r_state == S_BURST) | w_block_rdy);
  assign w_full       = (level == FULL_LVL);
  // A full buffer still takes the sample when a read frees a slot on the same edge
  assign w_wr_acc     = sample_valid & (~w_full | w_rd);
  assign w_drop       = sample_valid & w_full & ~w_rd;
  assign w_last       = (r_burst_cnt == CNT_W'(BLOCK_LEN - 1));
  assign is_there_256 = (r_state == S_IDLE) & w_block_rdy;

`ifdef ADC_BUF_TEST_PATTERN_EN
  logic [15:0] r_pat;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_pat <= 16'd0;
    end else if (sample_valid) begin
      r_pat <= r_pat + 16'd1;
    end
  end

  assign w_wdata = DATA_W'(r_pat);
`else
  assign w_wdata = sample_in;
`endif

  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wp] <= w_wdata;
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      data_out <= '0;
    end else if (w_rd) begin
      data_out <= r_mem[r_rp];
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      level      <= '0;
      drop_count <= 16'd0;
      rd_err     <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_wr_acc, w_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (w_drop && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
      if (rdreq && r_state == S_IDLE && !w_block_rdy) begin
        rd_err <= 1'b1;
      end
    end
  end

  // Burst counter is zero in IDLE, so one compare finds the final read from either state
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= '0;
    end else if (w_rd) begin
      if (w_last) begin
        r_state     <= S_IDLE;
        r_burst_cnt <= '0;
      end else begin
        r_state     <= S_BURST;
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_block_buffer.sv
// Directed bench for adc_block_buffer: queue-based model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_adc_block_buffer;
  localparam int DEPTH = 512;
  localparam int BLK   = 256;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic [15:0] sample_in = 16'd0;
  logic        sample_valid = 1'b0;
  logic        rdreq = 1'b0;
  logic [15:0] data_out;
  logic        is_there_256;
  logic [9:0]  level;
  logic [15:0] drop_count;
  logic        rd_err;

  adc_block_buffer #(.DATA_W(16), .ADDR_W(9), .BLOCK_LEN(BLK)) dut (
    .clock(clock), .aclr_n(aclr_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .rdreq(rdreq), .data_out(data_out), .is_there_256(is_there_256), .level(level),
    .drop_count(drop_count), .rd_err(rd_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: buffer contents as a FIFO queue, burst tracked as reads still owed
  logic [15:0] m_q[$];
  int          m_left = 0;
  int          m_drop = 0;
  bit          m_err = 1'b0;
  logic [15:0] m_dout = 16'd0;
  logic [15:0] m_pat = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_left = 0;
    m_drop = 0;
    m_err  = 1'b0;
    m_dout = 16'd0;
    m_pat  = 16'd0;
  endtask

  task automatic model_step();
    bit          full;
    bit          legal;
    logic [15:0] wv;
    full  = (m_q.size() >= DEPTH);
    legal = rdreq && (m_left > 0 || m_q.size() >= BLK);
    if (rdreq && !legal) m_err = 1'b1;
`ifdef ADC_BUF_TEST_PATTERN_EN
    wv = m_pat;
`else
    wv = sample_in;
`endif
    if (sample_valid) m_pat = m_pat + 16'd1;
    if (legal) begin
      m_dout = m_q.pop_front();
      m_left = (m_left == 0) ? BLK - 1 : m_left - 1;
    end
    if (sample_valid) begin
      if (!full || legal) m_q.push_back(wv);
      else if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (aclr_n) model_step();
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("data_out", 32'(data_out), 32'(m_dout));
      check("level", 32'(level), 32'(m_q.size()));
      check("is_there_256", 32'(is_there_256), 32'((m_left == 0) && (m_q.size() >= BLK)));
      check("drop_count", 32'(drop_count), 32'(m_drop));
      check("rd_err", 32'(rd_err), 32'(m_err));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_is_there", 32'(is_there_256), 32'd0);
    aclr_n = 1'b1;
    tick();

    // 255 samples: no block yet; the 256th raises the flag on the following cycle
    for (int i = 0; i < 255; i++) begin
      sample_valid = 1'b1; sample_in = 16'(i); tick();
    end
    sample_valid = 1'b0; tick();
    check("lvl_255", 32'(level), 32'd255);
    check("blk_255", 32'(is_there_256), 32'd0);
    sample_valid = 1'b1; sample_in = 16'd255; tick();
    sample_valid = 1'b0;
    check("blk_256", 32'(is_there_256), 32'd1);
    tick();

    for (int i = 0; i < BLK; i++) begin
      rdreq = 1'b1; tick();
      if (i == 0) begin
        check("burst_first", 32'(data_out), 32'd0);
        check("burst_flag_low", 32'(is_there_256), 32'd0);
      end
    end
    rdreq = 1'b0;
    check("burst_last", 32'(data_out), 32'd255);
    check("burst_lvl0", 32'(level), 32'd0);
    tick();

    // Overfill: 600 strobes into 512 slots
    for (int i = 0; i < 600; i++) begin
      sample_valid = 1'b1; sample_in = 16'(i); tick();
    end
    sample_valid = 1'b0; tick();
    check("full_lvl", 32'(level), 32'd512);
    check("full_drop", 32'(drop_count), 32'd88);

    // Writes alongside reads while full are accepted without drops
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1; sample_in = 16'(7000 + i); rdreq = 1'b1; tick();
      if (i == 0) check("full_rw_lvl", 32'(level), 32'd512);
    end
    sample_valid = 1'b0;
    check("full_rw_drop", 32'(drop_count), 32'd88);
    check("full_rw_data", 32'(data_out), 32'd9);
    for (int i = 10; i < BLK; i++) begin
      rdreq = 1'b1; tick();
    end
    rdreq = 1'b0;
    check("full_blk_last", 32'(data_out), 32'd255);
    check("full_after_lvl", 32'(level), 32'd266);
    check("reassert", 32'(is_there_256), 32'd1);
    tick();

    // Fresh start, then an illegal read at level 10
    aclr_n = 1'b0; model_reset(); tick();
    aclr_n = 1'b1; tick();
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1; sample_in = 16'(100 + i); tick();
    end
    sample_valid = 1'b0; rdreq = 1'b1; tick();
    rdreq = 1'b0;
    check("err_flag", 32'(rd_err), 32'd1);
    check("err_lvl", 32'(level), 32'd10);
    check("err_dout", 32'(data_out), 32'd0);
    tick();

    // Reset in the middle of the 100th read of a burst
    for (int i = 10; i < BLK; i++) begin
      sample_valid = 1'b1; sample_in = 16'(100 + i); tick();
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 99; i++) begin
      rdreq = 1'b1; tick();
    end
    check("pre_rst_dout", 32'(data_out), 32'd198);
    #2;
    aclr_n = 1'b0; model_reset();
    #1;
    check("midrst_dout", 32'(data_out), 32'd0);
    check("midrst_lvl", 32'(level), 32'd0);
    check("midrst_err", 32'(rd_err), 32'd0);
    check("midrst_blk", 32'(is_there_256), 32'd0);
    rdreq = 1'b0;
    tick(); tick();
    aclr_n = 1'b1; tick();
    for (int i = 0; i < 255; i++) begin
      sample_valid = 1'b1; sample_in = 16'(3000 + i); tick();
    end
    sample_valid = 1'b0; tick();
    check("refill_blk_255", 32'(is_there_256), 32'd0);
    sample_valid = 1'b1; sample_in = 16'd3255; tick();
    sample_valid = 1'b0;
    check("refill_blk_256", 32'(is_there_256), 32'd1);
    tick(); tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
